// File: rtl/rc_pot_scheduler.sv
// rc_pot_scheduler: time-shares one charge/measure engine over NCH RC pot pins, reporting counts on valid/ready.
// Define RCP_CHAN_MASK_EN to add chan_mask, which skips disabled channels during the scan.
module rc_pot_scheduler #(
    parameter int NCH           = 4,
    parameter int CW            = 24,
    parameter int CHARGE_TICKS  = 12000,
    parameter int TIMEOUT_TICKS = 2**20
) (
    input  logic                   clki,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [NCH-1:0]         pin_in,
`ifdef RCP_CHAN_MASK_EN
    input  logic [NCH-1:0]         chan_mask,
`endif
    output logic [NCH-1:0]         drive_hi,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [$clog2(NCH)-1:0] res_chan,
    output logic [CW-1:0]          res_value,
    output logic                   res_timeout
);
    localparam int CHW = $clog2(NCH);
    typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, REPORT} state_t;
    state_t state_q, state_d;
    logic [CHW-1:0] chan_q, chan_d, res_chan_q, res_chan_d, cand, sel;
    logic [CW-1:0] cnt_q, cnt_d, res_value_q, res_value_d;
    logic res_timeout_q, res_timeout_d, found;
    logic [NCH-1:0] pin_m_q, pin_m_d, pin_s_q, pin_s_d, mask, rot;
    logic [CHW:0] sum;
`ifdef RCP_CHAN_MASK_EN
    assign mask = chan_mask;
`else
    assign mask = '1;
`endif
    // Next enabled channel at or after the candidate, wrapping; smallest offset wins.
    always_comb begin
        cand = (state_q == REPORT) ? ((chan_q == CHW'(NCH-1)) ? '0 : chan_q + 1'b1) : chan_q;
        rot = NCH'({mask, mask} >> cand);
        found = 1'b0;
        sum = {1'b0, cand};
        for (int i = NCH-1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                sum = {1'b0, cand} + (CHW+1)'(i);
            end
        end
        sel = (sum >= (CHW+1)'(NCH)) ? CHW'(sum - (CHW+1)'(NCH)) : CHW'(sum);
    end
    always_comb begin
        pin_m_d = pin_in;
        pin_s_d = pin_m_q;
        state_d = state_q;
        chan_d = chan_q;
        cnt_d = cnt_q;
        res_chan_d = res_chan_q;
        res_value_d = res_value_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable && found) begin
                    state_d = CHARGE;
                    chan_d = sel;
                end
            end
            CHARGE: begin
                cnt_d = (cnt_q == CW'(CHARGE_TICKS-1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(CHARGE_TICKS-1)) ? MEASURE : CHARGE;
            end
            MEASURE: begin
                cnt_d = cnt_q + 1'b1;
                // A low pin wins over the timeout when both land on the same cycle.
                if (!pin_s_q[chan_q] || cnt_q == CW'(TIMEOUT_TICKS-1)) begin
                    state_d = REPORT;
                    cnt_d = '0;
                    res_chan_d = chan_q;
                    res_timeout_d = pin_s_q[chan_q];
                    res_value_d = pin_s_q[chan_q] ? CW'(TIMEOUT_TICKS) : cnt_q;
                end
            end
            default: begin
                cnt_d = '0;
                if (res_ready) begin
                    chan_d = sel;
                    state_d = (enable && found) ? CHARGE : IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clki) begin
        if (!resetn) begin
            state_q <= IDLE;
            chan_q <= '0;
            cnt_q <= '0;
            res_chan_q <= '0;
            res_value_q <= '0;
            res_timeout_q <= 1'b0;
            pin_m_q <= '0;
            pin_s_q <= '0;
        end else begin
            state_q <= state_d;
            chan_q <= chan_d;
            cnt_q <= cnt_d;
            res_chan_q <= res_chan_d;
            res_value_q <= res_value_d;
            res_timeout_q <= res_timeout_d;
            pin_m_q <= pin_m_d;
            pin_s_q <= pin_s_d;
        end
    end
    assign drive_hi = (state_q == CHARGE) ? NCH'(1) << chan_q : '0;
    assign busy = state_q != IDLE;
    assign res_valid = state_q == REPORT;
    assign res_chan = res_chan_q;
    assign res_value = res_value_q;
    assign res_timeout = res_timeout_q;
endmodule

// File: tb/tb_rc_pot_scheduler.sv
// tb_rc_pot_scheduler: randomized scan of rc_pot_scheduler against a channel-level model of counts and order.
// Define RCP_CHAN_MASK_EN to also exercise chan_mask.
module tb_rc_pot_scheduler;
    localparam int NCH = 4, CW = 12, CT = 8, TT = 100;
    logic clki = 1'b0, resetn = 1'b0, enable = 1'b0, res_ready = 1'b0;
    logic [NCH-1:0] pin_in = '1;
    logic [NCH-1:0] drive_hi;
    logic busy, res_valid, res_timeout;
    logic [1:0] res_chan;
    logic [CW-1:0] res_value;
    logic [NCH-1:0] model_mask = '1;
    int n_cmp = 0, n_bad = 0, exp_next = 0;
`ifdef RCP_CHAN_MASK_EN
    logic [NCH-1:0] chan_mask = '1;
`endif

    rc_pot_scheduler #(.NCH(NCH), .CW(CW), .CHARGE_TICKS(CT), .TIMEOUT_TICKS(TT)) dut (
        .clki(clki), .resetn(resetn), .enable(enable), .pin_in(pin_in),
`ifdef RCP_CHAN_MASK_EN
        .chan_mask(chan_mask),
`endif
        .drive_hi(drive_hi), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_chan(res_chan), .res_value(res_value), .res_timeout(res_timeout));

    always #5 clki = ~clki;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Model: first enabled channel at or after cand, -1 if none.
    function automatic int pick(input int cand);
        for (int i = 0; i < NCH; i++)
            if (model_mask[(cand + i) % NCH]) return (cand + i) % NCH;
        return -1;
    endfunction

    // Pin lowered d cycles into MEASURE is seen after the synchroniser: count d+1, capped at TT.
    function automatic int m_val(input int d);
        return (d < 0 || d + 1 >= TT) ? TT : d + 1;
    endfunction

    function automatic int m_to(input int d);
        return (d < 0 || d + 1 >= TT) ? 1 : 0;
    endfunction

    function automatic int m_meas(input int d);
        return m_to(d) ? TT : m_val(d) + 1;
    endfunction

    // Runs one channel: observes charge, lowers its pin d cycles after release (d<0: never), holds ready low for hold cycles.
    task automatic run_chan(input int d, input int hold, input bit drop_en,
                            output bit ok, output int ch, output int chg, output int meas,
                            output int rch, output int val, output int to, output bit stable, output int vafter);
        logic [NCH-1:0] first;
        int w;
        ok = 1; ch = -1; chg = 0; meas = 0; rch = -1; val = -1; to = -1; stable = 0; vafter = -1; w = 0;
        while (drive_hi === '0 && w < 40) begin @(negedge clki); w++; end
        if (drive_hi === '0) begin ok = 0; return; end
        first = drive_hi;
        for (int i = 0; i < NCH; i++) if (first == NCH'(1) << i) ch = i;
        while (drive_hi === first && chg < 1000) begin
            if (drop_en && chg == 3) enable = 1'b0;
            chg++;
            @(negedge clki);
        end
        while (res_valid !== 1'b1 && meas < 1000) begin
            if (ch >= 0 && meas == d - 1) pin_in[ch] = 1'b0;
            meas++;
            @(negedge clki);
        end
        if (res_valid !== 1'b1) begin ok = 0; return; end
        rch = int'(res_chan); val = int'(res_value); to = int'(res_timeout);
        if (ch >= 0) pin_in[ch] = 1'b1;
        stable = 1;
        repeat (hold) begin
            @(negedge clki);
            if (res_valid !== 1'b1 || int'(res_chan) != rch || int'(res_value) != val ||
                int'(res_timeout) != to || drive_hi !== '0 || busy !== 1'b1) stable = 0;
        end
        res_ready = 1'b1;
        @(negedge clki);
        res_ready = 1'b0;
        vafter = int'(res_valid);
    endtask

    task automatic test_reset;
        resetn = 1'b0; enable = 1'b0; res_ready = 1'b0; pin_in = '1;
        repeat (3) @(negedge clki);
        n_cmp++; if (drive_hi !== '0) begin n_bad++; $display("FAIL reset_drive got %b exp 0", drive_hi); end
        n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_busy_valid got %b%b exp 00", busy, res_valid); end
        n_cmp++; if (res_chan !== '0 || res_value !== '0 || res_timeout !== 1'b0) begin
            n_bad++; $display("FAIL reset_record got %0d/%0d/%b exp 0/0/0", res_chan, res_value, res_timeout); end
        resetn = 1'b1;
        repeat (5) @(negedge clki);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_enable busy got %b exp 0", busy); end
        exp_next = 0;
    endtask

    task automatic test_basic;
        bit ok, st; int ch, chg, meas, rch, val, to, va;
        enable = 1'b1;
        run_chan(20, 0, 1'b0, ok, ch, chg, meas, rch, val, to, st, va);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done got timeout exp record"); end
        n_cmp++; if (ch != 0 || rch != 0) begin n_bad++; $display("FAIL basic_chan got %0d/%0d exp 0", ch, rch); end
        n_cmp++; if (chg != CT) begin n_bad++; $display("FAIL basic_charge got %0d exp %0d", chg, CT); end
        n_cmp++; if (val != 21 || val != m_val(20) || to != 0) begin n_bad++; $display("FAIL basic_value got %0d/%0d exp 21/0", val, to); end
        n_cmp++; if (meas != m_meas(20)) begin n_bad++; $display("FAIL basic_meas got %0d exp %0d", meas, m_meas(20)); end
        n_cmp++; if (va != 0) begin n_bad++; $display("FAIL basic_valid_drop got %0d exp 0", va); end
        exp_next = 1;
    endtask

    task automatic test_timeout;
        bit ok, st; int ch, chg, meas, rch, val, to, va;
        run_chan(-1, 0, 1'b0, ok, ch, chg, meas, rch, val, to, st, va);
        n_cmp++; if (!ok || ch != 1 || rch != 1) begin n_bad++; $display("FAIL timeout_chan got %0d/%0d exp 1", ch, rch); end
        n_cmp++; if (val != TT || to != 1) begin n_bad++; $display("FAIL timeout_value got %0d/%0d exp %0d/1", val, to, TT); end
        n_cmp++; if (meas != TT) begin n_bad++; $display("FAIL timeout_meas got %0d exp %0d", meas, TT); end
        exp_next = 2;
    endtask

    task automatic test_backpressure;
        bit ok, st; int ch, chg, meas, rch, val, to, va, d;
        d = $urandom_range(1, 50);
        run_chan(d, 50, 1'b0, ok, ch, chg, meas, rch, val, to, st, va);
        n_cmp++; if (!ok || rch != 2) begin n_bad++; $display("FAIL bp_chan got %0d exp 2", rch); end
        n_cmp++; if (val != m_val(d) || to != m_to(d)) begin n_bad++; $display("FAIL bp_value got %0d/%0d exp %0d/%0d", val, to, m_val(d), m_to(d)); end
        n_cmp++; if (!st) begin n_bad++; $display("FAIL bp_stable got unstable exp held record"); end
        exp_next = 3;
    endtask

    task automatic test_boundary;
        bit ok, st; int ch, chg, meas, rch, val, to, va;
        run_chan(TT - 2, 0, 1'b0, ok, ch, chg, meas, rch, val, to, st, va);
        n_cmp++; if (!ok || rch != 3 || val != TT - 1 || to != 0) begin
            n_bad++; $display("FAIL bound_pin_wins got %0d/%0d/%0d exp 3/%0d/0", rch, val, to, TT - 1); end
        run_chan(TT - 1, 0, 1'b0, ok, ch, chg, meas, rch, val, to, st, va);
        n_cmp++; if (!ok || rch != 0 || val != TT || to != 1) begin
            n_bad++; $display("FAIL bound_timeout got %0d/%0d/%0d exp 0/%0d/1", rch, val, to, TT); end
        exp_next = 1;
    endtask

    task automatic test_random;
        bit ok, st; int ch, chg, meas, rch, val, to, va, d, e;
        for (int k = 0; k < 6; k++) begin
            d = $urandom_range(1, 110);
            e = pick(exp_next);
            run_chan(d, $urandom_range(0, 3), 1'b0, ok, ch, chg, meas, rch, val, to, st, va);
            n_cmp++; if (!ok || ch != e || rch != e || chg != CT) begin
                n_bad++; $display("FAIL rand_chan got %0d/%0d/%0d exp %0d/%0d", ch, rch, chg, e, CT); end
            n_cmp++; if (val != m_val(d) || to != m_to(d) || meas != m_meas(d) || !st) begin
                n_bad++; $display("FAIL rand_value d=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", d, val, to, meas, m_val(d), m_to(d), m_meas(d)); end
            exp_next = (e + 1) % NCH;
        end
    endtask

    task automatic test_enable_drop;
        bit ok, st; int ch, chg, meas, rch, val, to, va, idle_bad;
        resetn = 1'b0; @(negedge clki); resetn = 1'b1;
        exp_next = 0; enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_chan(10, 0, k == 4, ok, ch, chg, meas, rch, val, to, st, va);
            n_cmp++; if (!ok || rch != k % NCH || val != m_val(10)) begin
                n_bad++; $display("FAIL scan_order k=%0d got %0d/%0d exp %0d/%0d", k, rch, val, k % NCH, m_val(10)); end
        end
        exp_next = 1;
        idle_bad = 0;
        repeat (10) begin
            if (busy !== 1'b0 || drive_hi !== '0) idle_bad++;
            @(negedge clki);
        end
        n_cmp++; if (idle_bad != 0) begin n_bad++; $display("FAIL drop_idle got %0d busy cycles exp 0", idle_bad); end
        enable = 1'b1;
        run_chan(10, 0, 1'b0, ok, ch, chg, meas, rch, val, to, st, va);
        n_cmp++; if (!ok || rch != exp_next) begin n_bad++; $display("FAIL resume_chan got %0d exp %0d", rch, exp_next); end
        exp_next = 2;
    endtask

    task automatic test_reset_mid;
        int w;
        w = 0;
        while (drive_hi !== 4'b0100 && w < 40) begin @(negedge clki); w++; end
        while (drive_hi !== '0 && w < 80) begin @(negedge clki); w++; end
        n_cmp++; if (w >= 80) begin n_bad++; $display("FAIL mid_reach got no chan2 measure exp chan2 measure"); end
        repeat (5) @(negedge clki);
        resetn = 1'b0; @(negedge clki);
        n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0 || drive_hi !== '0) begin
            n_bad++; $display("FAIL mid_reset got busy=%b valid=%b drive=%b exp 0/0/0", busy, res_valid, drive_hi); end
        n_cmp++; if (res_value !== '0 || res_chan !== '0) begin n_bad++; $display("FAIL mid_reset_rec got %0d/%0d exp 0/0", res_value, res_chan); end
        resetn = 1'b1; @(negedge clki);
        n_cmp++; if (drive_hi !== 4'b0001) begin n_bad++; $display("FAIL mid_restart got %b exp 0001", drive_hi); end
    endtask

`ifdef RCP_CHAN_MASK_EN
    task automatic test_mask;
        bit ok, st; int ch, chg, meas, rch, val, to, va, e, act;
        resetn = 1'b0; enable = 1'b0; chan_mask = 4'b1010; model_mask = 4'b1010;
        @(negedge clki); resetn = 1'b1; exp_next = 0; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = pick(exp_next);
            run_chan($urandom_range(1, 30), 0, k == 3, ok, ch, chg, meas, rch, val, to, st, va);
            n_cmp++; if (!ok || rch != e || ch != e) begin n_bad++; $display("FAIL mask_chan k=%0d got %0d exp %0d", k, rch, e); end
            exp_next = (e + 1) % NCH;
        end
        chan_mask = '0; model_mask = '0; enable = 1'b1; act = 0;
        repeat (30) begin
            @(negedge clki);
            if (busy !== 1'b0 || res_valid !== 1'b0) act++;
        end
        n_cmp++; if (act != 0) begin n_bad++; $display("FAIL mask_zero got %0d active cycles exp 0", act); end
        chan_mask = 4'b0100; model_mask = 4'b0100;
        e = pick(exp_next);
        run_chan(5, 0, 1'b0, ok, ch, chg, meas, rch, val, to, st, va);
        n_cmp++; if (!ok || rch != e) begin n_bad++; $display("FAIL mask_reselect got %0d exp %0d", rch, e); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_backpressure();
        test_boundary();
        test_random();
        test_enable_drop();
        test_reset_mid();
`ifdef RCP_CHAN_MASK_EN
        test_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
